iterative_divider: RTL and testbench

- Multi-cycle RV32M divide/remainder unit that sits directly downstream of the execute-stage subtractor.
- Instantiates the subtractor block (enable_i, data0_i, data1_i, result_o) to form the trial difference each iteration, so it consumes that block's output every cycle.
- Implements DIV, DIVU, REM and REMU with RISC-V-mandated divide-by-zero and overflow results.
- Uses valid/ready handshakes on both sides so the pipeline can stall on it.

---
 rtl/iterative_divider.sv | 144 ++++++++++++++
 tb/tb_iterative_divider.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/iterative_divider.sv
// RV32M restoring divider: DIV/DIVU/REM/REMU with valid/ready on both sides.
// One quotient bit per cycle through the shared execute-stage subtractor.

module subtractor #(
  parameter int W = 33
) (
  input  logic         enable_i,
  input  logic [W-1:0] data0_i,
  input  logic [W-1:0] data1_i,
  output logic [W-1:0] result_o
);

  assign result_o = enable_i ? (data0_i - data1_i) : '0;

endmodule

module iterative_divider #(
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          valid_i,
  output logic          ready_o,
  input  logic [1:0]    op_i,
  input  logic [DW-1:0] dividend_i,
  input  logic [DW-1:0] divisor_i,
  output logic          valid_o,
  input  logic          ready_i,
  output logic [DW-1:0] result_o,
  output logic          busy_o
);

  localparam int CW = $clog2(DW);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [DW-1:0] rem_q, quo_q, div_q, result_q;
  logic          quo_neg_q, rem_neg_q, sel_rem_q;

  logic          accept, signed_op, a_neg, b_neg;
  logic          div_zero, overflow, special;
  logic [DW-1:0] abs_a, abs_b, special_res;
  logic [DW:0]   shifted, diff;
  logic          sub_en, diff_nonneg;
  logic [DW-1:0] rem_next, quo_next, rem_final, quo_final;

  assign accept    = valid_i && (state_q == IDLE);
  assign signed_op = ~op_i[0];
  assign a_neg     = signed_op & dividend_i[DW-1];
  assign b_neg     = signed_op & divisor_i[DW-1];
  assign abs_a     = a_neg ? (~dividend_i + 1'b1) : dividend_i;
  assign abs_b     = b_neg ? (~divisor_i + 1'b1) : divisor_i;

  assign div_zero  = (divisor_i == '0);
  assign overflow  = signed_op && (dividend_i == {1'b1, {(DW-1){1'b0}}}) && (divisor_i == '1);
  assign special   = div_zero || overflow;

  // Divide-by-zero wins over overflow; RISC-V results bypass the iteration entirely
  always_comb begin
    special_res = '0;
    if (div_zero)
      special_res = op_i[1] ? dividend_i : '1;
    else
      special_res = op_i[1] ? '0 : dividend_i;
  end

  // Trial subtraction on DW+1 bits so the borrow is the MSB even for full-range unsigned divisors
  assign shifted     = {rem_q, quo_q[DW-1]};
  assign sub_en      = (state_q == CALC);
  assign diff_nonneg = ~diff[DW];
  assign rem_next    = diff_nonneg ? diff[DW-1:0] : shifted[DW-1:0];
  assign quo_next    = {quo_q[DW-2:0], diff_nonneg};
  assign quo_final   = quo_neg_q ? (~quo_q + 1'b1) : quo_q;
  assign rem_final   = rem_neg_q ? (~rem_q + 1'b1) : rem_q;

  subtractor #(.W(DW + 1)) u_sub (
    .enable_i (sub_en),
    .data0_i  (shifted),
    .data1_i  ({1'b0, div_q}),
    .result_o (diff)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = special ? DONE : CALC;
      CALC: if (cnt_q == CW'(DW - 1)) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: if (ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      div_q     <= '0;
      result_q  <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      sel_rem_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (special) begin
              result_q <= special_res;
            end else begin
              rem_q     <= '0;
              quo_q     <= abs_a;
              div_q     <= abs_b;
              cnt_q     <= '0;
              quo_neg_q <= a_neg ^ b_neg;
              rem_neg_q <= a_neg;
              sel_rem_q <= op_i[1];
            end
          end
        end
        CALC: begin
          rem_q <= rem_next;
          quo_q <= quo_next;
          cnt_q <= cnt_q + CW'(1);
        end
        FIX: result_q <= sel_rem_q ? rem_final : quo_final;
        default: ;
      endcase
    end
  end

  assign ready_o  = (state_q == IDLE);
  assign busy_o   = (state_q != IDLE);
  assign valid_o  = (state_q == DONE);
  assign result_o = result_q;

endmodule

// File: tb/tb_iterative_divider.sv
// Scoreboard bench for iterative_divider: directed vectors queued at issue,
// a negedge monitor checks results, latency, stability and handshake rules.

module tb_iterative_divider;

  localparam int DW = 32;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          valid_i = 1'b0;
  logic          ready_i = 1'b1;
  logic [1:0]    op_i = 2'b00;
  logic [DW-1:0] dividend_i = '0;
  logic [DW-1:0] divisor_i = '0;
  logic          ready_o, valid_o, busy_o;
  logic [DW-1:0] result_o;

  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

  iterative_divider #(.DW(DW)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .op_i       (op_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .result_o   (result_o),
    .busy_o     (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [DW-1:0] result;
    int            latency;
    string         name;
  } exp_t;

  exp_t          sb_q[$];
  int            n_checks = 0;
  int            n_fail = 0;
  int            cyc = 0;
  int            accept_cyc = 0;
  bit            in_flight = 0;
  bit            seen_valid = 0;
  logic [DW-1:0] held_result = '0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: accept edge is the posedge following a negedge with valid_i && ready_o
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      in_flight  = 0;
      seen_valid = 0;
    end else begin
      if (in_flight) begin
        check_output("ready_low_while_busy", {31'b0, ready_o}, '0);
        check_output("busy_high", {31'b0, busy_o}, 32'd1);
      end
      if (valid_o) begin
        if (sb_q.size() == 0) begin
          check_output("unexpected_valid", {31'b0, valid_o}, '0);
        end else begin
          if (!seen_valid) begin
            seen_valid  = 1;
            held_result = result_o;
            check_int({sb_q[0].name, "_latency"}, cyc + 1 - accept_cyc, sb_q[0].latency);
          end else begin
            check_output({sb_q[0].name, "_stable"}, result_o, held_result);
          end
          if (ready_i) begin
            check_output(sb_q[0].name, result_o, sb_q[0].result);
            void'(sb_q.pop_front());
            in_flight  = 0;
            seen_valid = 0;
          end
        end
      end else if (seen_valid) begin
        check_output("valid_dropped", {31'b0, valid_o}, 32'd1);
        seen_valid = 0;
      end
      if (valid_i && ready_o) begin
        in_flight  = 1;
        accept_cyc = cyc + 1;
      end
    end
  end

  task automatic wait_ready();
    int t = 0;
    while (!ready_o && t < 200) begin
      @(posedge clk_i); #1;
      t++;
    end
    if (!ready_o) check_output("ready_timeout", {31'b0, ready_o}, 32'd1);
  endtask

  // Issue one request; inputs are scrambled right after the accept edge
  task automatic apply_stimulus(input string name, input logic [1:0] op, input logic [DW-1:0] a,
                                input logic [DW-1:0] b, input logic [DW-1:0] exp, input int lat);
    wait_ready();
    op_i       = op;
    dividend_i = a;
    divisor_i  = b;
    valid_i    = 1'b1;
    sb_q.push_back('{result: exp, latency: lat, name: name});
    @(posedge clk_i); #1;
    valid_i    = 1'b0;
    op_i       = ~op;
    dividend_i = ~a;
    divisor_i  = b + 32'd1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t;
    repeat (2) @(posedge clk_i);
    #1;
    check_output("reset_ready", {31'b0, ready_o}, 32'd1);
    check_output("reset_valid", {31'b0, valid_o}, '0);
    check_output("reset_busy", {31'b0, busy_o}, '0);
    check_output("reset_result", result_o, '0);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Abort a divide mid-flight
    apply_stimulus("divu_aborted", OP_DIVU, 32'd100, 32'd7, 32'd14, 34);
    repeat (9) @(posedge clk_i);
    #1;
    rst_ni = 1'b0;
    #1;
    check_output("midreset_valid", {31'b0, valid_o}, '0);
    check_output("midreset_ready", {31'b0, ready_o}, 32'd1);
    check_output("midreset_busy", {31'b0, busy_o}, '0);
    check_output("midreset_result", result_o, '0);
    sb_q.delete();
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    apply_stimulus("divu_9_3", OP_DIVU, 32'd9, 32'd3, 32'd3, 34);

    apply_stimulus("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 34);
    apply_stimulus("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2, 34);
    apply_stimulus("divu_max_1", OP_DIVU, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 34);
    apply_stimulus("div_m7_2", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34);
    apply_stimulus("rem_m7_2", OP_REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34);
    apply_stimulus("div_7_m2", OP_DIV, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 34);
    apply_stimulus("rem_7_m2", OP_REM, 32'd7, 32'hFFFFFFFE, 32'd1, 34);
    apply_stimulus("div_m8_m2", OP_DIV, 32'hFFFFFFF8, 32'hFFFFFFFE, 32'd4, 34);
    apply_stimulus("div_5_0", OP_DIV, 32'd5, 32'd0, 32'hFFFFFFFF, 1);
    apply_stimulus("remu_5_0", OP_REMU, 32'd5, 32'd0, 32'd5, 1);
    apply_stimulus("divu_0_0", OP_DIVU, 32'd0, 32'd0, 32'hFFFFFFFF, 1);
    apply_stimulus("rem_m5_0", OP_REM, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 1);
    apply_stimulus("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    apply_stimulus("rem_ovf", OP_REM, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1);
    apply_stimulus("divu_nonovf", OP_DIVU, 32'h80000000, 32'hFFFFFFFF, 32'd0, 34);
    apply_stimulus("remu_nonovf", OP_REMU, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 34);

    // Consumer back-pressure: hold ready_i low for 5 cycles once the result appears
    wait_ready();
    ready_i = 1'b0;
    apply_stimulus("divu_held", OP_DIVU, 32'd1000, 32'd9, 32'd111, 34);
    t = 0;
    while (!valid_o && t < 100) begin
      @(posedge clk_i); #1;
      t++;
    end
    check_output("held_valid_seen", {31'b0, valid_o}, 32'd1);
    repeat (5) @(posedge clk_i);
    #1;
    ready_i = 1'b1;

    // valid_i held high across two requests
    wait_ready();
    op_i       = OP_DIVU;
    dividend_i = 32'd50;
    divisor_i  = 32'd6;
    valid_i    = 1'b1;
    sb_q.push_back('{result: 32'd8, latency: 34, name: "b2b_first"});
    @(posedge clk_i); #1;
    op_i       = OP_REM;
    dividend_i = 32'hFFFFFFCE;
    divisor_i  = 32'd6;
    sb_q.push_back('{result: 32'hFFFFFFFE, latency: 34, name: "b2b_second"});
    wait_ready();
    @(posedge clk_i); #1;
    valid_i = 1'b0;

    t = 0;
    while (sb_q.size() != 0 && t < 200) begin
      @(posedge clk_i); #1;
      t++;
    end
    check_int("drain_pending", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
